// File: rtl/uart_rx_frame_ctrl_if.sv
// Payload byte stream from the frame controller to the host.
//   out_valid : a payload byte is available (source to sink)
//   out_data  : the payload byte (source to sink)
//   out_last  : marks the final payload byte of the frame (source to sink)
//   out_ready : the sink accepts the byte this cycle (sink to source)
// Modport master is the frame controller. Modport slave is the host.
interface uart_rx_frame_ctrl_if;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller that sits downstream of a UART byte receiver.
// It hunts for SOF_BYTE, then reads a length byte, the payload and an XOR
// checksum (len ^ payload). The payload is held in an internal buffer until
// the checksum has been verified. Only good frames are drained to the host on
// a valid/ready stream. A malformed or stalled frame is dropped, and the drop
// is reported with a coded one-cycle err pulse.
//
// Ports:
//   clk, rst        : clock, and a synchronous active-low reset
//   en              : enable; when low the controller is forced to IDLE
//   rx_dv/rx_data/rx_perr : byte strobe, data and parity flag from the receiver
//   out_if (master) : payload stream (out_valid/out_data/out_last/out_ready)
//   frame_ok        : pulse when the last byte of a good frame is accepted
//   err, err_code   : abort/overrun pulse and the last error code
//                     (0 parity, 1 length, 2 checksum, 3 timeout, 4 overrun)
//   frm_cnt         : count of good frames; wraps
//   err_cnt         : count of err pulses; saturates at 255
module uart_rx_frame_ctrl #(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 rx_dv,
  input  logic [7:0]           rx_data,
  input  logic                 rx_perr,
  uart_rx_frame_ctrl_if.master out_if,
  output logic                 frame_ok,
  output logic                 err,
  output logic [2:0]           err_code,
  output logic [7:0]           frm_cnt,
  output logic [7:0]           err_cnt
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int AW    = $clog2(MAX_LEN);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ERR_PARITY   = 3'd0;
  localparam logic [2:0] ERR_LENGTH   = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd3;
  localparam logic [2:0] ERR_OVERRUN  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrap_inc8(input logic [7:0] v);
    return v + 8'd1;
  endfunction

  state_t             state_q, state_nxt;
  logic [IDX_W-1:0]   idx_q, idx_nxt;
  logic [IDX_W-1:0]   rd_idx_q, rd_idx_nxt;
  logic [IDX_W-1:0]   len_q;
  logic [7:0]         chk_q, chk_nxt;
  logic [TW-1:0]      tmo_q, tmo_nxt;
  logic               out_valid_q, out_valid_nxt;
  logic               out_last_q, out_last_nxt;
  logic               frame_ok_q, frame_ok_nxt;
  logic               err_q, err_nxt;
  logic [2:0]         err_code_q, err_code_nxt;
  logic [7:0]         frm_cnt_q, frm_cnt_nxt;
  logic [7:0]         err_cnt_q, err_cnt_nxt;

  logic               buf_we;
  logic               len_we;
  logic               abort;
  logic [2:0]         abort_code;
  logic               timed;

  logic [7:0]         buf_mem [MAX_LEN];

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state_q;
    idx_nxt       = idx_q;
    rd_idx_nxt    = rd_idx_q;
    chk_nxt       = chk_q;
    tmo_nxt       = tmo_q;
    out_valid_nxt = out_valid_q;
    out_last_nxt  = out_last_q;
    frame_ok_nxt  = 1'b0;
    err_nxt       = 1'b0;
    err_code_nxt  = err_code_q;
    frm_cnt_nxt   = frm_cnt_q;
    err_cnt_nxt   = err_cnt_q;
    buf_we        = 1'b0;
    len_we        = 1'b0;
    abort         = 1'b0;
    abort_code    = ERR_PARITY;
    timed         = 1'b0;

    if (!en) begin
      state_nxt     = S_IDLE;
      out_valid_nxt = 1'b0;
      out_last_nxt  = 1'b0;
      tmo_nxt       = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          tmo_nxt = '0;
          if (rx_dv && !rx_perr && (rx_data == SOF_BYTE)) begin
            state_nxt = S_LEN;
            chk_nxt   = 8'h00;
          end
        end

        S_LEN: begin
          timed = 1'b1;
          if (rx_dv) begin
            tmo_nxt = '0;
            if (rx_perr) begin
              abort      = 1'b1;
              abort_code = ERR_PARITY;
            end else if ((rx_data == 8'h00) || (rx_data > MAX_LEN_B)) begin
              abort      = 1'b1;
              abort_code = ERR_LENGTH;
            end else begin
              len_we    = 1'b1;
              chk_nxt   = rx_data;
              idx_nxt   = '0;
              state_nxt = S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          timed = 1'b1;
          if (rx_dv) begin
            tmo_nxt = '0;
            if (rx_perr) begin
              abort      = 1'b1;
              abort_code = ERR_PARITY;
            end else begin
              buf_we  = 1'b1;
              chk_nxt = chk_q ^ rx_data;
              idx_nxt = idx_q + IDX_W'(1);
              if (idx_q == len_q - IDX_W'(1)) begin
                state_nxt = S_CHK;
              end
            end
          end
        end

        S_CHK: begin
          timed = 1'b1;
          if (rx_dv) begin
            tmo_nxt = '0;
            if (rx_perr) begin
              abort      = 1'b1;
              abort_code = ERR_PARITY;
            end else if (rx_data == chk_q) begin
              state_nxt     = S_DRAIN;
              rd_idx_nxt    = '0;
              out_valid_nxt = 1'b1;
              out_last_nxt  = (len_q == IDX_W'(1));
            end else begin
              abort      = 1'b1;
              abort_code = ERR_CHECKSUM;
            end
          end
        end

        S_DRAIN: begin
          tmo_nxt = '0;
          if (out_valid_q && out_if.out_ready) begin
            if (out_last_q) begin
              out_valid_nxt = 1'b0;
              out_last_nxt  = 1'b0;
              frame_ok_nxt  = 1'b1;
              frm_cnt_nxt   = wrap_inc8(frm_cnt_q);
              state_nxt     = S_IDLE;
            end else begin
              rd_idx_nxt   = rd_idx_q + IDX_W'(1);
              out_last_nxt = ((rd_idx_q + IDX_W'(1)) == (len_q - IDX_W'(1)));
            end
          end
          // The buffer is busy draining, so an incoming byte is dropped.
          // The drain itself is not disturbed.
          if (rx_dv) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_OVERRUN;
            err_cnt_nxt  = sat_inc8(err_cnt_q);
          end
        end

        default: begin
          state_nxt     = S_IDLE;
          out_valid_nxt = 1'b0;
          out_last_nxt  = 1'b0;
        end
      endcase

      // A byte that arrives in the expiry cycle takes priority, because
      // timed is only checked when no byte is present.
      if (timed && !rx_dv) begin
        if (tmo_q == TMO_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          tmo_nxt = tmo_q + TW'(1);
        end
      end

      if (abort) begin
        state_nxt    = S_IDLE;
        tmo_nxt      = '0;
        err_nxt      = 1'b1;
        err_code_nxt = abort_code;
        err_cnt_nxt  = sat_inc8(err_cnt_q);
      end
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_idx_q    <= '0;
      chk_q       <= 8'h00;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      frm_cnt_q   <= 8'h00;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_nxt;
      idx_q       <= idx_nxt;
      rd_idx_q    <= rd_idx_nxt;
      chk_q       <= chk_nxt;
      tmo_q       <= tmo_nxt;
      out_valid_q <= out_valid_nxt;
      out_last_q  <= out_last_nxt;
      frame_ok_q  <= frame_ok_nxt;
      err_q       <= err_nxt;
      err_code_q  <= err_code_nxt;
      frm_cnt_q   <= frm_cnt_nxt;
      err_cnt_q   <= err_cnt_nxt;
    end
  end

  // Payload storage and the latched length; no reset needed
  always_ff @(posedge clk) begin
    if (rst && en && buf_we) begin
      buf_mem[idx_q[AW-1:0]] <= rx_data;
    end
    if (rst && en && len_we) begin
      len_q <= IDX_W'(rx_data);
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_data  = buf_mem[rd_idx_q[AW-1:0]];
  assign frame_ok         = frame_ok_q;
  assign err              = err_q;
  assign err_code         = err_code_q;
  assign frm_cnt          = frm_cnt_q;
  assign err_cnt          = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl with MAX_LEN=16, SOF=A5 and TIMEOUT_CYCLES=50.
// A frame-level reference model tracks the bytes seen since SOF and the queue
// of payload bytes still to be delivered. Every cycle the DUT outputs are
// compared against that model. Directed scenarios add literal expectations.
module tb_uart_rx_frame_ctrl;
  localparam int          MAX_LEN = 16;
  localparam logic [7:0]  SOF     = 8'hA5;
  localparam int          TMO     = 50;

  logic       clk;
  logic       rst;
  logic       en;
  logic       rx_dv;
  logic [7:0] rx_data;
  logic       rx_perr;
  logic       frame_ok;
  logic       err;
  logic [2:0] err_code;
  logic [7:0] frm_cnt;
  logic [7:0] err_cnt;

  uart_rx_frame_ctrl_if out_if();

  uart_rx_frame_ctrl #(
    .MAX_LEN        (MAX_LEN),
    .SOF_BYTE       (SOF),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .rx_dv    (rx_dv),
    .rx_data  (rx_data),
    .rx_perr  (rx_perr),
    .out_if   (out_if),
    .frame_ok (frame_ok),
    .err      (err),
    .err_code (err_code),
    .frm_cnt  (frm_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0] fq[$];
  logic [7:0] drain_q[$];
  bit         in_frame;
  int         silence;
  bit         m_live = 1'b0;
  logic       m_fok;
  logic       m_err;
  logic [2:0] m_code;
  logic [7:0] m_frm;
  logic [7:0] m_errc;

  task automatic raise(input logic [2:0] c);
    m_err  = 1'b1;
    m_code = c;
    if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
    in_frame = 1'b0;
    silence  = 0;
  endtask

  always @(posedge clk) begin
    logic [7:0] x;
    m_fok = 1'b0;
    m_err = 1'b0;
    if (!rst) begin
      m_live   = 1'b1;
      in_frame = 1'b0;
      silence  = 0;
      fq.delete();
      drain_q.delete();
      m_code = 3'd0;
      m_frm  = 8'd0;
      m_errc = 8'd0;
    end else if (!en) begin
      in_frame = 1'b0;
      silence  = 0;
      drain_q.delete();
    end else if (drain_q.size() > 0) begin
      if (out_if.out_ready) begin
        if (drain_q.size() == 1) begin
          m_fok = 1'b1;
          m_frm = m_frm + 8'd1;
        end
        void'(drain_q.pop_front());
      end
      if (rx_dv) raise(3'd4);
    end else if (!in_frame) begin
      if (rx_dv && !rx_perr && rx_data == SOF) begin
        in_frame = 1'b1;
        silence  = 0;
        fq.delete();
      end
    end else if (rx_dv) begin
      silence = 0;
      if (rx_perr) raise(3'd0);
      else begin
        fq.push_back(rx_data);
        if (fq.size() == 1 && (rx_data == 8'd0 || int'(rx_data) > MAX_LEN)) raise(3'd1);
        else if (fq.size() == int'(fq[0]) + 2) begin
          x = 8'd0;
          for (int i = 0; i < fq.size() - 1; i++) x = x ^ fq[i];
          if (x == rx_data) begin
            for (int i = 1; i < fq.size() - 1; i++) drain_q.push_back(fq[i]);
            in_frame = 1'b0;
          end else raise(3'd2);
        end
      end
    end else begin
      silence++;
      if (silence == TMO) raise(3'd3);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_live) begin
      cmp("out_valid", 32'(out_if.out_valid), 32'(drain_q.size() > 0));
      cmp("out_last",  32'(out_if.out_last),  32'(drain_q.size() == 1));
      if (drain_q.size() > 0) cmp("out_data", 32'(out_if.out_data), 32'(drain_q[0]));
      cmp("frame_ok",  32'(frame_ok), 32'(m_fok));
      cmp("err",       32'(err),      32'(m_err));
      cmp("err_code",  32'(err_code), 32'(m_code));
      cmp("frm_cnt",   32'(frm_cnt),  32'(m_frm));
      cmp("err_cnt",   32'(err_cnt),  32'(m_errc));
    end
  end

  // ---------------- event monitor for literal checks ----------------
  logic [7:0] beats[$];
  int         fok_seen = 0;
  int         err_seen = 0;

  always @(negedge clk) begin
    if (out_if.out_valid && out_if.out_ready) beats.push_back(out_if.out_data);
    if (frame_ok) fok_seen++;
    if (err) err_seen++;
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic send(input logic [7:0] b, input logic perr);
    rx_dv = 1'b1; rx_data = b; rx_perr = perr;
    @(posedge clk); #1;
    rx_dv = 1'b0; rx_perr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drained(input string name, input int max);
    int k = 0;
    while (out_if.out_valid && k < max) begin idle(1); k++; end
    cmp({name, "_drain_timeout"}, 32'(out_if.out_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; idle(2); rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int t_aa;
    int k;
    logic [7:0] x;
    rst = 1'b0; en = 1'b1; rx_dv = 1'b0; rx_data = 8'h00; rx_perr = 1'b0;
    out_if.out_ready = 1'b1;
    idle(3);
    rst = 1'b1;
    cmp("rst_valid", 32'(out_if.out_valid), 32'd0);
    cmp("rst_err_code", 32'(err_code), 32'd0);
    cmp("rst_cnts", {16'd0, frm_cnt, err_cnt}, 32'd0);
    idle(2);

    // 1: good frame
    beats.delete();
    send(SOF, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h03, 0);
    wait_drained("t1", 20);
    idle(1);
    cmp("t1_nbeats", 32'(beats.size()), 32'd3);
    if (beats.size() == 3) cmp("t1_data", {8'd0, beats[0], beats[1], beats[2]}, 32'h00112233);
    cmp("t1_fok", 32'(fok_seen), 32'd1);
    cmp("t1_frm_cnt", 32'(frm_cnt), 32'd1);
    cmp("t1_err_seen", 32'(err_seen), 32'd0);

    // 2: backpressure, 5 stall cycles before each beat
    beats.delete();
    out_if.out_ready = 1'b0;
    send(SOF, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h03, 0);
    for (int b = 0; b < 3; b++) begin
      idle(5);
      cmp("t2_valid_stalled", 32'(out_if.out_valid), 32'd1);
      cmp("t2_fok_before", 32'(fok_seen), 32'd1);
      out_if.out_ready = 1'b1;
      idle(1);
      out_if.out_ready = 1'b0;
    end
    idle(1);
    out_if.out_ready = 1'b1;
    cmp("t2_nbeats", 32'(beats.size()), 32'd3);
    cmp("t2_fok_after", 32'(fok_seen), 32'd2);
    cmp("t2_frm_cnt", 32'(frm_cnt), 32'd2);

    // 3: bad checksum, then a good one-byte frame
    beats.delete();
    send(SOF, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'h00, 0);
    idle(1);
    cmp("t3_err_code", 32'(err_code), 32'd2);
    cmp("t3_err_cnt", 32'(err_cnt), 32'd1);
    cmp("t3_nbeats_bad", 32'(beats.size()), 32'd0);
    send(SOF, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h5B, 0);
    wait_drained("t3", 10);
    idle(1);
    cmp("t3_good_beat", 32'(beats.size() == 1 ? beats[0] : 8'h00), 32'h5A);
    cmp("t3_frm_cnt", 32'(frm_cnt), 32'd3);

    // 4: length / parity aborts, then a max-length frame
    do_reset();
    send(SOF, 0); send(8'h00, 0); idle(1);
    cmp("t4_len0_code", 32'(err_code), 32'd1);
    send(SOF, 0); send(8'(MAX_LEN + 1), 0); idle(1);
    cmp("t4_lenbig_code", 32'(err_code), 32'd1);
    send(SOF, 0); send(8'h02, 0); send(8'hAA, 1); idle(1);
    cmp("t4_perr_code", 32'(err_code), 32'd0);
    cmp("t4_err_cnt", 32'(err_cnt), 32'd3);
    beats.delete();
    x = 8'(MAX_LEN);
    send(SOF, 0); send(8'(MAX_LEN), 0);
    for (int i = 0; i < MAX_LEN; i++) begin
      send(8'(i * 13 + 7), 0);
      x = x ^ 8'(i * 13 + 7);
    end
    send(x, 0);
    wait_drained("t4", 40);
    idle(1);
    cmp("t4_max_nbeats", 32'(beats.size()), 32'(MAX_LEN));
    cmp("t4_max_frm_cnt", 32'(frm_cnt), 32'd1);

    // 5: timeout 50 cycles after AA, then overrun during drain
    send(SOF, 0); send(8'h02, 0); send(8'hAA, 0);
    t_aa = cyc;
    e0 = err_seen;
    k = 0;
    while (!err && k < 60) begin idle(1); k++; end
    cmp("t5_tmo_delay", 32'(cyc - t_aa), 32'd50);
    cmp("t5_tmo_code", 32'(err_code), 32'd3);
    idle(1);
    cmp("t5_tmo_one_pulse", 32'(err_seen - e0), 32'd1);
    beats.delete();
    out_if.out_ready = 1'b0;
    send(SOF, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'h13, 0);
    idle(2);
    send(8'h55, 0);
    idle(1);
    cmp("t5_ovr_code", 32'(err_code), 32'd4);
    cmp("t5_ovr_valid", 32'(out_if.out_valid), 32'd1);
    out_if.out_ready = 1'b1;
    wait_drained("t5", 10);
    idle(1);
    cmp("t5_ovr_beats", 32'(beats.size() == 2 ? {beats[0], beats[1]} : 16'h0), 32'hAABB);
    cmp("t5_err_cnt", 32'(err_cnt), 32'd5);

    // 6: reset mid-payload, enable drop mid-drain
    e0 = err_seen;
    send(SOF, 0); send(8'h03, 0); send(8'h11, 0);
    do_reset();
    idle(1);
    cmp("t6_rst_cnts", {16'd0, frm_cnt, err_cnt}, 32'd0);
    cmp("t6_rst_no_err", 32'(err_seen - e0), 32'd0);
    out_if.out_ready = 1'b0;
    send(SOF, 0); send(8'h02, 0); send(8'hAA, 0); send(8'hBB, 0); send(8'h13, 0);
    idle(2);
    en = 1'b0;
    idle(1);
    cmp("t6_en_valid_drop", 32'(out_if.out_valid), 32'd0);
    send(SOF, 0); send(8'h01, 0);
    en = 1'b1;
    send(8'h5A, 0); send(8'h5B, 0);
    idle(2);
    cmp("t6_en_ignored", 32'(out_if.out_valid), 32'd0);
    cmp("t6_en_no_err", 32'(err_seen - e0), 32'd0);
    out_if.out_ready = 1'b1;
    send(SOF, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h5B, 0);
    wait_drained("t6", 10);
    idle(2);
    cmp("t6_frm_cnt", 32'(frm_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Frame-level controller placed downstream of the UART byte receiver. It consumes the receiver's byte strobe, data and parity-error flag and hunts for a start-of-frame byte. It then collects a length byte, the payload and an XOR checksum, buffering the payload internally. Only verified frames are released to the host on a valid/ready byte stream; malformed or stalled frames are aborted with a coded error pulse.

Parameters:
MAX_LEN, 16, maximum payload bytes; internal buffer depth (2..255).
SOF_BYTE, 8'hA5, start-of-frame marker.
TIMEOUT_CYCLES, 100000, clk cycles of inter-byte silence that abort a frame in progress (>=2).

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-low reset.
en  input  1  controller enable; low forces IDLE.
rx_dv  input  1  one-cycle byte strobe from the receiver.
rx_data  input  8  received byte, valid when rx_dv=1.
rx_perr  input  1  parity error for the byte, valid when rx_dv=1.
out_valid  output  1  payload byte available.
out_data  output  8  payload byte.
out_last  output  1  marks the final payload byte.
out_ready  input  1  consumer accepts the byte.
frame_ok  output  1  one-cycle pulse when the last byte of a good frame is accepted.
err  output  1  one-cycle abort/overrun pulse.
err_code  output  3  0 parity, 1 length, 2 checksum, 3 timeout, 4 overrun; holds last code.
frm_cnt  output  8  good frames, wraps 255->0.
err_cnt  output  8  err pulses, saturates at 255.

Behaviour:
- Reset (rst=0 at posedge clk): state=IDLE; out_valid, out_last, frame_ok, err=0; err_code=0; frm_cnt=0; err_cnt=0; idx=0; rd_idx=0; chk=0; timeout counter=0. Buffer contents are undefined after reset. Reset takes effect mid-frame or mid-drain without any err pulse.
- en=0: at the next edge the state goes to IDLE, out_valid drops and rx_dv is ignored; no err pulse; counters hold.
- Every rule below applies only when rst=1 and en=1. A byte event is rx_dv=1.
- IDLE: a byte equal to SOF_BYTE with rx_perr=0 moves to LEN and clears chk. Every other byte is silently ignored.
- LEN:
  - rx_perr=1 aborts with code 0.
  - len=0 or len>MAX_LEN aborts with code 1.
  - Otherwise latch len, set chk=len, idx=0, and move to PAYLOAD.
- PAYLOAD:
  - rx_perr=1 aborts with code 0.
  - Otherwise buf[idx]<=byte, chk<=chk^byte, idx++.
  - The byte written at idx=len-1 moves the state to CHK.
- CHK:
  - rx_perr=1 aborts with code 0.
  - byte==chk moves to DRAIN with rd_idx=0; out_valid=1 on the next cycle (1-cycle latency).
  - Otherwise abort with code 2.
- DRAIN:
  - out_data=buf[rd_idx]; out_last=(rd_idx==len-1).
  - out_data and out_last are stable while out_valid=1 and out_ready=0.
  - A beat transfers when out_valid and out_ready are both 1, then rd_idx increments.
  - On the out_last beat: out_valid=0 next cycle, frame_ok pulses, frm_cnt++, state=IDLE.
  - A byte event during DRAIN is dropped with err and code 4. The drain continues and the state is unchanged.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CHK. It clears on entry to those states and on every byte event.
  - Reaching TIMEOUT_CYCLES aborts with code 3.
  - A byte event in the same cycle as expiry wins: the byte is processed and the counter clears.
- Abort: err=1 for exactly one cycle, err_code updated, err_cnt increments (saturating), state=IDLE next cycle. A byte arriving in the abort cycle is not re-examined for SOF.
- Width rules:
  - idx and rd_idx are clog2(MAX_LEN+1) bits.
  - The timeout counter is clog2(TIMEOUT_CYCLES+1) bits.
  - Checksum = len XOR all payload bytes; SOF is excluded.
- out_valid, out_last, frame_ok, err and err_code are all registered outputs.

Test Plan:
1. Good frame: bytes A5,03,11,22,33, checksum 03^11^22^33=03, out_ready=1. Response: out_data 11,22,33; out_last on 33; one frame_ok pulse; frm_cnt=1; err never asserted.
2. Backpressure: same frame with out_ready low for 5 cycles on each byte. Response: out_data and out_last hold while stalled; 3 beats total; frame_ok only after the 33 beat is accepted.
3. Bad checksum: A5,02,AA,BB,00. Response: err pulse with err_code=2, err_cnt=1, no out_valid. A following good frame is delivered normally.
4. Length/parity abort: A5,00 gives code 1. A5 then LEN=MAX_LEN+1 gives code 1. A5,02,AA with rx_perr=1 on AA gives code 0. Response: err_cnt=3, state back to IDLE each time.
5. Timeout and overrun, with TIMEOUT_CYCLES=50: A5,02,AA then silence gives err code 3 exactly 50 cycles after AA. A byte injected during DRAIN with out_ready=0 gives code 4 and the drain still completes.
6. Reset/enable: reset in mid-PAYLOAD clears every output and counter with no err pulse. en=0 in mid-DRAIN drops out_valid next cycle. rx_dv is ignored while en=0.
